// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding select generation and load-use stall detection.
// Shadows rd/rs/control of in-flight instructions through ID/EX, EX/MEM, MEM/WB.

module fwd_sel #(
  parameter int REG_AW = 5
) (
  input  logic              idex_valid_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic              exm_wr_i,
  input  logic [REG_AW-1:0] exm_rd_i,
  input  logic              mwb_wr_i,
  input  logic [REG_AW-1:0] mwb_rd_i,
  output logic [1:0]        sel_o
);
  always_comb begin
    sel_o = 2'b00;
    if (idex_valid_i) begin
      // Youngest producer wins; x0 is never a forwarding source.
      if (exm_wr_i && (exm_rd_i != '0) && (exm_rd_i == src_i))
        sel_o = 2'b10;
      else if (mwb_wr_i && (mwb_rd_i != '0) && (mwb_rd_i == src_i))
        sel_o = 2'b01;
    end
  end
endmodule

module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } idex_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } wb_t;

  idex_t idex_q, idex_d;
  wb_t   exm_q, mwb_q;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic [NUM_SRC-1:0][REG_AW-1:0] src;
  logic [NUM_SRC-1:0][1:0]        sel;

  always_comb begin
    stall = idex_q.valid && idex_q.mem_read && (idex_q.rd != '0) && id_valid &&
            ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));
  end

  always_comb begin
    idex_d = '0;
    if (id_valid && !stall && !flush) begin
      idex_d.valid     = 1'b1;
      idex_d.rs1       = id_rs1;
      idex_d.rs2       = id_rs2;
      idex_d.rd        = id_rd;
      idex_d.reg_write = id_reg_write;
      idex_d.mem_read  = id_mem_read;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q        <= '0;
      exm_q         <= '0;
      mwb_q         <= '0;
      stall_count_q <= '0;
    end else begin
      idex_q        <= idex_d;
      exm_q         <= '{valid: idex_q.valid, rd: idex_q.rd, reg_write: idex_q.reg_write};
      mwb_q         <= exm_q;
      stall_count_q <= stall_count_d;
    end
  end

  assign src[0] = idex_q.rs1;
  assign src[1] = idex_q.rs2;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_sel
    fwd_sel #(.REG_AW(REG_AW)) u_sel (
      .idex_valid_i (idex_q.valid),
      .src_i        (src[s]),
      .exm_wr_i     (exm_q.valid && exm_q.reg_write),
      .exm_rd_i     (exm_q.rd),
      .mwb_wr_i     (mwb_q.valid && mwb_q.reg_write),
      .mwb_rd_i     (mwb_q.rd),
      .sel_o        (sel[s])
    );
  end

  assign forward_a   = sel[0];
  assign forward_b   = sel[1];
  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding selects, load-use stall, flush, counter saturation.

module tb_fwd_hazard_unit;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_reg_write, id_mem_read, flush;
  logic [1:0]        forward_a, forward_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  int passed = 0;
  int total  = 0;

  fwd_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive the ID stage; outputs settle 1 time unit later.
  task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                       input logic rw, input logic mr);
    id_valid     = v;
    id_rs1       = REG_AW'(rs1);
    id_rs2       = REG_AW'(rs2);
    id_rd        = REG_AW'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic nop;
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held three cycles with random ID inputs
    reset = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), 1'($urandom), 1'($urandom));
      flush = 1'($urandom);
      tick();
      chk("rst_fa", forward_a, 2'b00);
      chk("rst_fb", forward_b, 2'b00);
      chk("rst_stall", stall, 1'b0);
      chk("rst_cnt", stall_count, 0);
    end
    flush = 1'b0;
    nop();
    reset = 1'b0;
    #1;
    chk("post_rst_fa", forward_a, 2'b00);
    chk("post_rst_stall", stall, 1'b0);

    // EX/MEM forward: add x5 ; add x6,x5,x7
    drive(1'b1, 1, 2, 5, 1'b1, 1'b0); tick();
    drive(1'b1, 5, 7, 6, 1'b1, 1'b0);
    chk("exm_nostall", stall, 1'b0);
    tick();
    chk("exm_fa", forward_a, 2'b10);
    chk("exm_fb", forward_b, 2'b00);

    // Priority: two writers of x5 ahead of a reader
    drive(1'b1, 1, 2, 5, 1'b1, 1'b0); tick();
    drive(1'b1, 3, 4, 5, 1'b1, 1'b0); tick();
    drive(1'b1, 5, 0, 7, 1'b1, 1'b0); tick();
    chk("prio_fa", forward_a, 2'b10);
    chk("prio_fb_x0", forward_b, 2'b00);

    // MEM/WB forward on A, EX/MEM forward on B
    drive(1'b1, 1, 2, 10, 1'b1, 1'b0); tick();
    drive(1'b1, 1, 2, 11, 1'b1, 1'b0); tick();
    drive(1'b1, 10, 11, 12, 1'b1, 1'b0); tick();
    chk("mwb_fa", forward_a, 2'b01);
    chk("mix_fb", forward_b, 2'b10);
    nop(); tick();
    chk("bubble_fa", forward_a, 2'b00);
    chk("bubble_fb", forward_b, 2'b00);
    tick(); tick();

    // Load-use: ld x8 ; add x9,x8,x8
    drive(1'b1, 1, 0, 8, 1'b1, 1'b1);
    chk("ld_nostall", stall, 1'b0);
    tick();
    drive(1'b1, 8, 8, 9, 1'b1, 1'b0);
    chk("lu_stall", stall, 1'b1);
    chk("lu_cnt_pre", stall_count, 0);
    tick();
    chk("lu_stall_drop", stall, 1'b0);
    chk("lu_ld_in_exm_fa", forward_a, 2'b00);
    chk("lu_cnt", stall_count, 1);
    tick();
    chk("lu_fa", forward_a, 2'b01);
    chk("lu_fb", forward_b, 2'b01);
    chk("lu_stall_once", stall, 1'b0);
    nop(); tick(); tick(); tick();

    // x0: load into x0 then a reader of x0
    drive(1'b1, 1, 0, 0, 1'b1, 1'b1); tick();
    drive(1'b1, 0, 0, 3, 1'b1, 1'b0);
    chk("x0_nostall", stall, 1'b0);
    tick();
    chk("x0_fa", forward_a, 2'b00);
    chk("x0_fb", forward_b, 2'b00);
    nop(); tick(); tick(); tick();

    // Flush over a load-use pair: stall still asserts, add is squashed
    drive(1'b1, 1, 0, 12, 1'b1, 1'b1); tick();
    drive(1'b1, 12, 12, 13, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_stall", stall, 1'b1);
    tick();
    flush = 1'b0;
    chk("fl_cnt", stall_count, 2);
    drive(1'b1, 13, 13, 14, 1'b0, 1'b0);
    chk("fl_nostall", stall, 1'b0);
    chk("fl_bubble_fa", forward_a, 2'b00);
    tick();
    chk("fl_sq_fa", forward_a, 2'b00);
    chk("fl_sq_fb", forward_b, 2'b00);
    drive(1'b1, 13, 13, 15, 1'b0, 1'b0); tick();
    chk("fl_sq2_fa", forward_a, 2'b00);
    nop(); tick(); tick(); tick();

    // Saturation: 20 more load-use pairs, counter starts at 2
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1, 0, 8, 1'b1, 1'b1); tick();
      drive(1'b1, 8, 2, 9, 1'b1, 1'b0); tick();
      tick();
      if (i == 11) chk("sat_14", stall_count, 14);
      if (i == 12) chk("sat_15", stall_count, 15);
    end
    chk("sat_hold", stall_count, 15);

    // Reset asserted mid-stall clears everything without a clock edge
    drive(1'b1, 1, 0, 8, 1'b1, 1'b1); tick();
    drive(1'b1, 2, 8, 9, 1'b1, 1'b0);
    chk("mid_stall", stall, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_cnt", stall_count, 0);
    chk("mid_rst_fa", forward_a, 2'b00);
    tick();
    reset = 1'b0;
    nop(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Pipeline control block that drives the 2-bit select inputs of the two 64-bit 3:1 operand forwarding muxes in the EX stage.
- Internally shadows the register-address and control fields of in-flight instructions through the ID/EX, EX/MEM and MEM/WB stages.
- Computes forwarding selects for the EX instruction, detects load-use hazards in ID, and counts stall cycles.

Parameters:
- REG_AW, 5, register address width (32 architectural registers, x0 hardwired zero).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  REG_AW  source register 1 of the ID instruction.
- id_rs2  input  REG_AW  source register 2 of the ID instruction.
- id_rd  input  REG_AW  destination register of the ID instruction.
- id_reg_write  input  1  ID instruction writes rd.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  taken branch resolved in EX; squash the ID instruction.
- forward_a  output  2  select for operand A mux.
- forward_b  output  2  select for operand B mux.
- stall  output  1  hold PC and IF/ID; insert a bubble into ID/EX.
- stall_count  output  CNT_W  number of cycles with stall=1, saturating.

Behaviour:
- Select encoding, fixed: 00 = register-file data, 01 = MEM/WB writeback data, 10 = EX/MEM ALU result. 11 is never driven.
- Internal stage registers:
  - ID/EX holds {valid, rs1, rs2, rd, reg_write, mem_read}.
  - EX/MEM and MEM/WB each hold {valid, rd, reg_write}.
- Reset, asynchronous: all valid bits, fields and stall_count clear to 0. forward_a = forward_b = 00 and stall = 0 while reset is high and on the first cycle after release.
- Each rising edge:
  - MEM/WB <= EX/MEM.
  - EX/MEM <= ID/EX.
  - ID/EX <= ID inputs, or a bubble (valid=0, reg_write=0, mem_read=0) when stall=1 or flush=1 or id_valid=0.
- forward_a is combinational from registered state only:
  - 10 if EX/MEM.valid & reg_write & rd!=0 & rd==IDEX.rs1.
  - else 01 if MEM/WB.valid & reg_write & rd!=0 & rd==IDEX.rs1.
  - else 00.
  - 00 whenever IDEX.valid=0.
- forward_b: identical to forward_a, using IDEX.rs2.
- Priority: EX/MEM beats MEM/WB when both match (youngest value wins).
- x0 is never forwarded, regardless of reg_write.
- stall (load-use), combinational: IDEX.valid & IDEX.mem_read & IDEX.rd!=0 & id_valid & (IDEX.rd==id_rs1 | IDEX.rd==id_rs2).
  - Lasts exactly one cycle per hazard. After the bubble the load is in EX/MEM and forward select 10 does not apply to loads; the dependent instruction picks the value up from MEM/WB (01) one cycle later.
- Load in EX/MEM: EX/MEM holds an address, not data. The extra stall cycle guarantees the dependent instruction is never in EX while the load sits in EX/MEM, so no special case is needed.
- flush and stall in the same cycle: flush wins. ID/EX gets a bubble, and stall still asserts for that cycle (harmless, since IF is redirected). The stall counter still increments.
- A read of a register written by the WB instruction in the same cycle is handled by the write-first register file, not by this block.
- stall_count: increments by 1 on each rising edge where stall=1, and holds at all-ones (no wrap).
- Reset asserted mid-stall: all state clears immediately and stall drops asynchronously.

Test Plan:
- Reset: hold reset 3 cycles with random inputs -> forward_a=forward_b=00, stall=0, stall_count=0.
- EX/MEM forward: add x5 then next-cycle add x6,x5,x7 -> when the consumer is in EX, forward_a=10, forward_b=00.
- MEM/WB forward and priority: writes to x5 two and one instructions ahead of a consumer of x5 -> forward_a=10. With one independent instruction between producer and consumer -> forward_a=01.
- Load-use: ld x8 followed by add x9,x8,x8 -> stall=1 for exactly one cycle, then forward_a=forward_b=01 when the add reaches EX; stall_count=1.
- x0 and flush: writer of x0 followed by a reader of x0 -> selects stay 00. Flush asserted with a load-use pair in ID -> the squashed instruction never produces forwarding, and the bubble propagates through all stages.
- Counter saturation with CNT_W=4: 20 load-use pairs -> stall_count stops at 15.
